ip_ram_arbiter: RTL and testbench

- Sits between the MapperRAM front end (client A) and a second cartridge function, e.g. MegaROM or SCC (client B), on one side, and the single PSRAM/SDRAM controller RAM I/F on the other.
- Converts each client's level-style rd/wr (held for the whole bus cycle) into exactly one controller request.
- Arbitrates round-robin between the two clients and allows one outstanding request.
- Routes read data back to the owning client and recovers from a stuck controller with a timeout.

---
 rtl/ip_ram_arbiter_pkg.sv | 17 +
 rtl/ip_ram_req_latch.sv | 47 ++++
 rtl/ip_ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_ip_ram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_ram_arbiter_pkg.sv
// Shared types and constants for the two-client RAM I/F arbiter.
package ip_ram_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_A = 1'b0,
      OWNER_B = 1'b1
   } owner_t;

   localparam logic [7:0] READ_TIMEOUT_DATA = 8'hFF;

endpackage

// File: rtl/ip_ram_req_latch.sv
// Turns one client's level-style rd/wr into a single latched request that
// stays pending until the arbiter grants it.
module ip_ram_req_latch
   import ip_ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = 22
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              rd,
   input  logic              wr,
   input  logic [ADDR_W-1:0] address,
   input  logic [7:0]        wdata,
   input  logic              clear,
   output logic              pend,
   output logic              is_wr,
   output logic [ADDR_W-1:0] req_addr,
   output logic [7:0]        req_wdata
);

   logic level;
   logic level_q;

   assign level = rd | wr;

   // clear only arrives while pend is set, so an edge in that cycle is dropped
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         level_q   <= 1'b0;
         pend      <= 1'b0;
         is_wr     <= 1'b0;
         req_addr  <= '0;
         req_wdata <= '0;
      end else begin
         level_q <= level;
         if (clear) begin
            pend <= 1'b0;
         end else if (level && !level_q && !pend) begin
            pend      <= 1'b1;
            is_wr     <= wr;
            req_addr  <= address;
            req_wdata <= wdata;
         end
      end
   end

endmodule

// File: rtl/ip_ram_arbiter.sv
// Round-robin arbiter sharing one RAM controller between two clients, with
// one outstanding request, read-data routing and a completion timeout.
module ip_ram_arbiter
   import ip_ram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W         = 22,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              a_rd,
   input  logic              a_wr,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [7:0]        a_wdata,
   output logic [7:0]        a_rdata,
   output logic              a_rdata_en,
   input  logic              b_rd,
   input  logic              b_wr,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [7:0]        b_wdata,
   output logic [7:0]        b_rdata,
   output logic              b_rdata_en,
   output logic              rd,
   output logic              wr,
   input  logic              busy,
   output logic [ADDR_W-1:0] address,
   output logic [7:0]        wdata,
   input  logic [7:0]        rdata,
   input  logic              rdata_en
);

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic              a_pend, a_is_wr, b_pend, b_is_wr;
   logic [ADDR_W-1:0] a_req_addr, b_req_addr;
   logic [7:0]        a_req_wdata, b_req_wdata;
   logic              clear_a, clear_b;

   state_t            state, state_n;
   owner_t            owner, last_owner, grant_owner;
   logic              grant, own_wr, deliver;
   logic [7:0]        deliver_data;
   logic [7:0]        wait_cnt, wait_cnt_inc;
   logic              grant_is_wr;
   logic [ADDR_W-1:0] grant_addr;
   logic [7:0]        grant_wdata;

   ip_ram_req_latch #(.ADDR_W(ADDR_W)) u_latch_a (
      .clk(clk), .n_reset(n_reset), .rd(a_rd), .wr(a_wr),
      .address(a_address), .wdata(a_wdata), .clear(clear_a),
      .pend(a_pend), .is_wr(a_is_wr), .req_addr(a_req_addr), .req_wdata(a_req_wdata)
   );

   ip_ram_req_latch #(.ADDR_W(ADDR_W)) u_latch_b (
      .clk(clk), .n_reset(n_reset), .rd(b_rd), .wr(b_wr),
      .address(b_address), .wdata(b_wdata), .clear(clear_b),
      .pend(b_pend), .is_wr(b_is_wr), .req_addr(b_req_addr), .req_wdata(b_req_wdata)
   );

   always_ff @(posedge clk) begin
      if (!n_reset) state <= ST_IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n      = state;
      grant        = 1'b0;
      grant_owner  = OWNER_A;
      deliver      = 1'b0;
      deliver_data = rdata;
      wait_cnt_inc = wait_cnt + 8'd1;
      case (state)
         ST_IDLE: begin
            if ((a_pend || b_pend) && !busy) begin
               grant = 1'b1;
               if (a_pend && b_pend)
                  grant_owner = (last_owner == OWNER_A) ? OWNER_B : OWNER_A;
               else if (b_pend)
                  grant_owner = OWNER_B;
               state_n = ST_ISSUE;
            end
         end
         ST_ISSUE: state_n = ST_WAIT;
         ST_WAIT: begin
            // a write may not finish in its first wait cycle: busy may not have risen yet
            if (!own_wr && rdata_en) begin
               deliver = 1'b1;
               state_n = ST_IDLE;
            end else if (own_wr && !busy && (wait_cnt != '0)) begin
               state_n = ST_IDLE;
            end else if (wait_cnt_inc == TIMEOUT_LIMIT) begin
               deliver      = !own_wr;
               deliver_data = READ_TIMEOUT_DATA;
               state_n      = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign clear_a     = grant && (grant_owner == OWNER_A);
   assign clear_b     = grant && (grant_owner == OWNER_B);
   assign grant_is_wr = (grant_owner == OWNER_B) ? b_is_wr     : a_is_wr;
   assign grant_addr  = (grant_owner == OWNER_B) ? b_req_addr  : a_req_addr;
   assign grant_wdata = (grant_owner == OWNER_B) ? b_req_wdata : a_req_wdata;

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         owner      <= OWNER_A;
         last_owner <= OWNER_B;
         own_wr     <= 1'b0;
         rd         <= 1'b0;
         wr         <= 1'b0;
         address    <= '0;
         wdata      <= '0;
         wait_cnt   <= '0;
         a_rdata    <= READ_TIMEOUT_DATA;
         b_rdata    <= READ_TIMEOUT_DATA;
         a_rdata_en <= 1'b0;
         b_rdata_en <= 1'b0;
      end else begin
         rd         <= 1'b0;
         wr         <= 1'b0;
         a_rdata_en <= 1'b0;
         b_rdata_en <= 1'b0;
         if (grant) begin
            owner      <= grant_owner;
            last_owner <= grant_owner;
            own_wr     <= grant_is_wr;
            address    <= grant_addr;
            wdata      <= grant_wdata;
            rd         <= !grant_is_wr;
            wr         <= grant_is_wr;
         end
         if (state == ST_ISSUE)
            wait_cnt <= '0;
         else if (state == ST_WAIT)
            wait_cnt <= wait_cnt_inc;
         if (deliver) begin
            if (owner == OWNER_A) begin
               a_rdata    <= deliver_data;
               a_rdata_en <= 1'b1;
            end else begin
               b_rdata    <= deliver_data;
               b_rdata_en <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ip_ram_arbiter.sv
// Directed and randomized bench for ip_ram_arbiter against a transaction-level
// model of grant order and read-data routing.
module tb_ip_ram_arbiter;

   localparam int AW = 22;
   localparam int TO = 8;

   logic          clk;
   logic          n_reset;
   logic          a_rd, a_wr, b_rd, b_wr;
   logic [AW-1:0] a_address, b_address;
   logic [7:0]    a_wdata, b_wdata;
   logic [7:0]    a_rdata, b_rdata;
   logic          a_rdata_en, b_rdata_en;
   logic          rd, wr, busy;
   logic [AW-1:0] address;
   logic [7:0]    wdata, rdata;
   logic          rdata_en;

   ip_ram_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .n_reset(n_reset),
      .a_rd(a_rd), .a_wr(a_wr), .a_address(a_address), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_rdata_en(a_rdata_en),
      .b_rd(b_rd), .b_wr(b_wr), .b_address(b_address), .b_wdata(b_wdata),
      .b_rdata(b_rdata), .b_rdata_en(b_rdata_en),
      .rd(rd), .wr(wr), .busy(busy), .address(address), .wdata(wdata),
      .rdata(rdata), .rdata_en(rdata_en)
   );

   typedef struct {
      bit            wr;
      logic [AW-1:0] addr;
      logic [7:0]    wd;
      int            cyc;
   } req_t;

   typedef struct {
      logic [7:0] d;
      int         cyc;
   } rsp_t;

   req_t       mon_req[$], exp_req[$];
   rsp_t       mon_a[$], mon_b[$];
   logic [7:0] exp_a[$], exp_b[$], resp_q[$];

   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   rd_lat = 2;
   int   wr_busy = 0;
   int   hang_req = 0;
   int   inject_cyc = -1;
   int   busy_last = -1;
   int   start_cyc = 0;
   int   m_hang = 0;
   bit   m_last_b = 1'b1;
   bit   use_fixed = 1'b0;
   logic [7:0] fixed_val = 8'h00;

   initial clk = 1'b0;
   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // monitor: records every controller request and client read pulse
   initial forever begin
      req_t r;
      @(negedge clk);
      if (rd === 1'b1 || wr === 1'b1) begin
         r.wr = (wr === 1'b1); r.addr = address; r.wd = wdata; r.cyc = cyc;
         mon_req.push_back(r);
      end
      if (a_rdata_en === 1'b1) mon_a.push_back('{d: a_rdata, cyc: cyc});
      if (b_rdata_en === 1'b1) mon_b.push_back('{d: b_rdata, cyc: cyc});
   end

   // controller responder: read latency, write busy window, optional hang
   initial begin
      int rd_cnt = 0;
      int busy_cnt = 0;
      int hang_used = 0;
      rdata_en = 1'b0; rdata = 8'h00; busy = 1'b0;
      forever begin
         @(negedge clk);
         rdata_en = 1'b0;
         if (busy_cnt > 0) begin
            busy = 1'b1; busy_cnt--; busy_last = cyc;
         end else begin
            busy = 1'b0;
         end
         if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               rdata_en = 1'b1;
               rdata = (resp_q.size() > 0) ? resp_q.pop_front() : 8'h00;
            end
         end
         if (cyc == inject_cyc) begin
            rdata_en = 1'b1; rdata = 8'h77;
         end
         if (rd === 1'b1) begin
            if (hang_used < hang_req) hang_used++;
            else rd_cnt = rd_lat;
         end
         if (wr === 1'b1) busy_cnt = wr_busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int req_cyc(input int i);
      return (i < mon_req.size()) ? mon_req[i].cyc : -1;
   endfunction

   function automatic int a_cyc(input int i);
      return (i < mon_a.size()) ? mon_a[i].cyc : -1;
   endfunction

   function automatic logic [7:0] next_rdata();
      return use_fixed ? fixed_val : 8'($urandom);
   endfunction

   task automatic model_one(input bit is_b, input bit w, input logic [AW-1:0] a, input logic [7:0] d);
      req_t r;
      logic [7:0] v;
      r.wr = w; r.addr = a; r.wd = d; r.cyc = 0;
      exp_req.push_back(r);
      if (!w) begin
         if (m_hang > 0) begin
            v = 8'hFF; m_hang--;
         end else begin
            v = next_rdata(); resp_q.push_back(v);
         end
         if (is_b) exp_b.push_back(v);
         else      exp_a.push_back(v);
      end
      m_last_b = is_b;
   endtask

   // ab/bb: raise rd together with wr (must still be a write)
   task automatic issue(input bit da, input bit aw, input bit ab, input logic [AW-1:0] aa, input logic [7:0] ad,
                        input bit db, input bit bw, input bit bb, input logic [AW-1:0] ba, input logic [7:0] bd,
                        input int hold);
      if (da && db) begin
         if (m_last_b) begin
            model_one(1'b0, aw, aa, ad); model_one(1'b1, bw, ba, bd);
         end else begin
            model_one(1'b1, bw, ba, bd); model_one(1'b0, aw, aa, ad);
         end
      end else if (da) model_one(1'b0, aw, aa, ad);
      else if (db)     model_one(1'b1, bw, ba, bd);
      if (da) begin
         a_rd = !aw || ab; a_wr = aw; a_address = aa; a_wdata = ad;
      end
      if (db) begin
         b_rd = !bw || bb; b_wr = bw; b_address = ba; b_wdata = bd;
      end
      start_cyc = cyc;
      repeat (hold) @(negedge clk);
      if (da) begin a_rd = 1'b0; a_wr = 1'b0; end
      if (db) begin b_rd = 1'b0; b_wr = 1'b0; end
   endtask

   task automatic clear_all();
      mon_req.delete(); exp_req.delete(); mon_a.delete(); mon_b.delete();
      exp_a.delete(); exp_b.delete(); resp_q.delete();
   endtask

   task automatic check_phase(input string tag);
      chk({tag, "_nreq"}, 32'(mon_req.size()), 32'(exp_req.size()));
      for (int i = 0; i < mon_req.size() && i < exp_req.size(); i++) begin
         chk({tag, "_kind"}, 32'(mon_req[i].wr), 32'(exp_req[i].wr));
         chk({tag, "_addr"}, 32'(mon_req[i].addr), 32'(exp_req[i].addr));
         if (exp_req[i].wr) chk({tag, "_wdata"}, 32'(mon_req[i].wd), 32'(exp_req[i].wd));
      end
      chk({tag, "_na"}, 32'(mon_a.size()), 32'(exp_a.size()));
      for (int i = 0; i < mon_a.size() && i < exp_a.size(); i++)
         chk({tag, "_adata"}, 32'(mon_a[i].d), 32'(exp_a[i]));
      chk({tag, "_nb"}, 32'(mon_b.size()), 32'(exp_b.size()));
      for (int i = 0; i < mon_b.size() && i < exp_b.size(); i++)
         chk({tag, "_bdata"}, 32'(mon_b[i].d), 32'(exp_b[i]));
      chk({tag, "_unused_resp"}, 32'(resp_q.size()), 32'd0);
      clear_all();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd"}, 32'(rd), 32'd0);
      chk({tag, "_wr"}, 32'(wr), 32'd0);
      chk({tag, "_address"}, 32'(address), 32'd0);
      chk({tag, "_wdata"}, 32'(wdata), 32'd0);
      chk({tag, "_a_rdata"}, 32'(a_rdata), 32'hFF);
      chk({tag, "_b_rdata"}, 32'(b_rdata), 32'hFF);
      chk({tag, "_a_rdata_en"}, 32'(a_rdata_en), 32'd0);
      chk({tag, "_b_rdata_en"}, 32'(b_rdata_en), 32'd0);
   endtask

   initial begin
      int s;
      bit da, db, aw, ab, bw, bb;
      n_reset = 1'b0;
      a_rd = 1'b0; a_wr = 1'b0; a_address = '0; a_wdata = '0;
      b_rd = 1'b0; b_wr = 1'b0; b_address = '0; b_wdata = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");

      // collision right after reset: A first, then B; B write released on 2nd wait cycle
      n_reset = 1'b1; m_last_b = 1'b1;
      issue(1, 0, 0, 22'h000111, 8'h00, 1, 1, 0, 22'h000222, 8'h22, 3);
      s = start_cyc;
      repeat (20) @(negedge clk);
      chk("coll1_latency", 32'(req_cyc(0)), 32'(s + 2));
      check_phase("coll1");
      issue(1, 0, 0, 22'h000333, 8'h00, 0, 0, 0, '0, 8'h00, 2);
      repeat (15) @(negedge clk);
      check_phase("solo_a");
      issue(1, 0, 0, 22'h000444, 8'h00, 1, 1, 1, 22'h000555, 8'h55, 3);
      s = start_cyc;
      repeat (20) @(negedge clk);
      chk("coll2_latency", 32'(req_cyc(0)), 32'(s + 2));
      chk("coll2_wr_release", 32'(req_cyc(1)), 32'(req_cyc(0) + 4));
      check_phase("coll2");

      // single read A, data 3 cycles after rd
      rd_lat = 3; use_fixed = 1'b1; fixed_val = 8'h5A;
      issue(1, 0, 0, 22'h012345, 8'h00, 0, 0, 0, '0, 8'h00, 10);
      repeat (10) @(negedge clk);
      chk("rd_a_pulse_cyc", 32'(a_cyc(0)), 32'(req_cyc(0) + 4));
      chk("rd_a_hold", 32'(a_rdata), 32'h5A);
      check_phase("rd_a");
      use_fixed = 1'b0;

      // write B with busy 5 cycles, A read queued behind it
      rd_lat = 2; wr_busy = 5;
      issue(0, 0, 0, '0, 8'h00, 1, 1, 0, 22'h3FFFFF, 8'hC3, 1);
      issue(1, 0, 0, 22'h000777, 8'h00, 0, 0, 0, '0, 8'h00, 2);
      repeat (20) @(negedge clk);
      chk("busy_next_req", 32'(req_cyc(1)), 32'(busy_last + 3));
      check_phase("wr_b");
      wr_busy = 0;

      // long level gives one request; a new edge gives another
      issue(1, 1, 0, 22'h0ABCDE, 8'h99, 0, 0, 0, '0, 8'h00, 40);
      repeat (10) @(negedge clk);
      check_phase("long1");
      issue(1, 1, 0, 22'h0ABCDE, 8'h9A, 0, 0, 0, '0, 8'h00, 3);
      repeat (10) @(negedge clk);
      check_phase("long2");

      // timeout on A read, B read pending behind it
      hang_req++; m_hang = 1;
      issue(1, 0, 0, 22'h000888, 8'h00, 0, 0, 0, '0, 8'h00, 2);
      issue(0, 0, 0, '0, 8'h00, 1, 0, 0, 22'h000889, 8'h00, 2);
      repeat (25) @(negedge clk);
      chk("timeout_pulse_cyc", 32'(a_cyc(0)), 32'(req_cyc(0) + TO + 1));
      chk("timeout_next_req", 32'(req_cyc(1)), 32'(req_cyc(0) + TO + 2));
      check_phase("timeout");

      // randomized traffic
      for (int it = 0; it < 24; it++) begin
         da = 1'($urandom_range(0, 1)); db = 1'($urandom_range(0, 1));
         if (!da && !db) da = 1'b1;
         aw = 1'($urandom_range(0, 1)); ab = 1'($urandom_range(0, 1));
         bw = 1'($urandom_range(0, 1)); bb = 1'($urandom_range(0, 1));
         rd_lat = $urandom_range(1, 4); wr_busy = $urandom_range(0, 3);
         issue(da, aw, ab, 22'($urandom), 8'($urandom), db, bw, bb, 22'($urandom), 8'($urandom),
               $urandom_range(1, 6));
         repeat (24) @(negedge clk);
      end
      check_phase("rand");
      wr_busy = 0; rd_lat = 2;

      // reset during a read wait, late rdata_en afterwards
      hang_req++;
      a_address = 22'h000999; a_rd = 1'b1;
      repeat (2) @(negedge clk);
      a_rd = 1'b0;
      @(negedge clk);
      n_reset = 1'b0;
      repeat (2) @(negedge clk);
      n_reset = 1'b1; m_last_b = 1'b1;
      inject_cyc = cyc + 1;
      repeat (6) @(negedge clk);
      check_reset_outputs("rst_mid");
      chk("rst_mid_nreq", 32'(mon_req.size()), 32'd1);
      chk("rst_mid_na", 32'(mon_a.size()), 32'd0);
      chk("rst_mid_nb", 32'(mon_b.size()), 32'd0);
      clear_all();
      issue(1, 1, 0, 22'h000AAA, 8'hA1, 1, 0, 0, 22'h000BBB, 8'h00, 2);
      repeat (20) @(negedge clk);
      check_phase("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
